// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
// Outputs follow capture by one cycle; stall holds, flush (dominant) loads a bubble, load_use asks ID to stall.
module id_ex_stage #(
  parameter int W = 32,
  parameter int CW = 3,
  parameter logic [CW-1:0] BUBBLE_CTRL = 3'd2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [W-1:0]  in_rs_val,
  input  logic [W-1:0]  in_rt_val,
  input  logic [W-1:0]  in_imm,
  input  logic [4:0]    in_rs_addr,
  input  logic [4:0]    in_rt_addr,
  input  logic [4:0]    in_rd_addr,
  input  logic [CW-1:0] in_alu_ctrl,
  input  logic          in_alusrc,
  input  logic          in_regwrite,
  input  logic          in_memread,
  input  logic          in_memwrite,
  input  logic          in_memtoreg,
  input  logic          exmem_regwrite,
  input  logic [4:0]    exmem_rd,
  input  logic [W-1:0]  exmem_res,
  input  logic          memwb_regwrite,
  input  logic [4:0]    memwb_rd,
  input  logic [W-1:0]  memwb_data,
  output logic [W-1:0]  Op1,
  output logic [W-1:0]  Op2,
  output logic [CW-1:0] ALUCtrl,
  output logic [W-1:0]  out_store_data,
  output logic          out_valid,
  output logic [4:0]    out_rd,
  output logic          out_regwrite,
  output logic          out_memread,
  output logic          out_memwrite,
  output logic          out_memtoreg,
  output logic          load_use
);

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic [W-1:0]  imm;
    logic [4:0]    rs_addr;
    logic [4:0]    rt_addr;
    logic [4:0]    rd;
    logic [CW-1:0] alu_ctrl;
    logic          alusrc;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
  } idex_t;

  localparam idex_t BUBBLE = '{alu_ctrl: BUBBLE_CTRL, default: '0};

  idex_t idex_q, idex_d;
  idex_t cap;
  logic [W-1:0] fwd_a, fwd_b;
  logic ex_is_load;

  // Control bits of an invalid ID slot are dropped so no stray write or memory access escapes.
  always_comb begin
    cap          = BUBBLE;
    cap.valid    = in_valid;
    cap.rs_val   = in_rs_val;
    cap.rt_val   = in_rt_val;
    cap.imm      = in_imm;
    cap.rs_addr  = in_rs_addr;
    cap.rt_addr  = in_rt_addr;
    cap.rd       = in_rd_addr;
    cap.alu_ctrl = in_alu_ctrl;
    cap.alusrc   = in_alusrc;
    cap.regwrite = in_regwrite & in_valid;
    cap.memread  = in_memread & in_valid;
    cap.memwrite = in_memwrite & in_valid;
    cap.memtoreg = in_memtoreg & in_valid;
  end

  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = BUBBLE;
    end else if (!stall) begin
      idex_d = cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= BUBBLE;
    end else begin
      idex_q <= idex_d;
    end
  end

  // EX/MEM is checked first: it holds the younger producer.
  assign fwd_a = (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idex_q.rs_addr)) ? exmem_res :
                 (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idex_q.rs_addr)) ? memwb_data :
                 idex_q.rs_val;

  assign fwd_b = (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idex_q.rt_addr)) ? exmem_res :
                 (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idex_q.rt_addr)) ? memwb_data :
                 idex_q.rt_val;

  assign Op1            = fwd_a;
  assign Op2            = idex_q.alusrc ? idex_q.imm : fwd_b;
  assign out_store_data = fwd_b;
  assign ALUCtrl        = idex_q.alu_ctrl;
  assign out_valid      = idex_q.valid;
  assign out_rd         = idex_q.rd;
  assign out_regwrite   = idex_q.valid & idex_q.regwrite;
  assign out_memread    = idex_q.valid & idex_q.memread;
  assign out_memwrite   = idex_q.valid & idex_q.memwrite;
  assign out_memtoreg   = idex_q.valid & idex_q.memtoreg;

  // rt only matters to the consumer when it is a register operand or store data.
  assign ex_is_load = out_valid && out_memread && (idex_q.rd != 5'd0);
  assign load_use   = ex_is_load &&
                      ((idex_q.rd == in_rs_addr) ||
                       ((idex_q.rd == in_rt_addr) && (!in_alusrc || in_memwrite)));

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding front end for the EX stage.
- Captures decoded operands and control fields from ID each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Presents final Op1/Op2/ALUCtrl straight to the ALU and flags load-use hazards back to ID.

Parameters:
- W, 32, datapath word width.
- CW, 3, ALU control field width.
- BUBBLE_CTRL, 3'd2, ALUCtrl value driven for a bubble (the ADDU code; harmless with zero operands).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold current contents
- flush  in  1  load a bubble
- in_valid  in  1  ID slot holds a real instruction
- in_rs_val  in  W  register-file rs read data
- in_rt_val  in  W  register-file rt read data
- in_imm  in  W  sign/zero-extended immediate
- in_rs_addr  in  5  rs number
- in_rt_addr  in  5  rt number
- in_rd_addr  in  5  destination number, already muxed rt/rd
- in_alu_ctrl  in  CW  ALU operation
- in_alusrc  in  1  1: Op2 = immediate
- in_regwrite, in_memread, in_memwrite, in_memtoreg  in  1 each  control bits
- exmem_regwrite  in  1  EX/MEM writes a register
- exmem_rd  in  5  EX/MEM destination
- exmem_res  in  W  EX/MEM ALU result
- memwb_regwrite  in  1  MEM/WB writes a register
- memwb_rd  in  5  MEM/WB destination
- memwb_data  in  W  MEM/WB writeback data
- Op1  out  W  ALU operand 1
- Op2  out  W  ALU operand 2
- ALUCtrl  out  CW  ALU operation
- out_store_data  out  W  forwarded rt value, for stores
- out_valid  out  1  EX slot holds a real instruction
- out_rd  out  5  registered destination
- out_regwrite, out_memread, out_memwrite, out_memtoreg  out  1 each  registered controls, forced 0 when out_valid=0
- load_use  out  1  ID must stall one cycle

Behaviour:
- Register update at posedge clk, priority order:
  - !rst_n (asynchronous) clears everything.
  - flush loads a bubble.
  - stall holds the current contents.
  - Otherwise all in_* fields are captured.
- flush has priority over stall when both are asserted.
- Bubble/reset state:
  - valid=0; all control bits 0; rd=0; all data fields 0; alu_ctrl=BUBBLE_CTRL.
  - Reset values of outputs: Op1=0, Op2=0, ALUCtrl=BUBBLE_CTRL, out_store_data=0, out_valid=0, out_rd=0, all out control bits 0, load_use=0.
- A capture with in_valid=0 also forces the control bits to 0. This guarantees no stray write or memory access.
- Latency: ID values appear on the outputs one cycle after capture. The forwarding muxes after the register are combinational, so there are no extra cycles.
- Forwarding for source A (rs), evaluated combinationally on the registered rs_addr:
  - If exmem_regwrite and exmem_rd!=0 and exmem_rd==rs_addr: use exmem_res.
  - Else if memwb_regwrite and memwb_rd!=0 and memwb_rd==rs_addr: use memwb_data.
  - Else: use the registered rs_val.
  - EX/MEM takes priority because it is the newer result.
- Forwarding for source B (rt): same rule, applied to rt_addr.
- Register 0 is never forwarded: it always reads the registered value.
- Op1 = forwarded A.
- Op2 = alusrc ? registered imm : forwarded B.
- out_store_data = forwarded B, regardless of alusrc.
- ALUCtrl = registered alu_ctrl.
- Forwarding applies to bubbles too; with zero addresses it is inert.
- load_use is combinational and asserted when all of the following hold:
  - out_valid and out_memread are 1;
  - out_rd != 0;
  - out_rd == in_rs_addr, or (out_rd == in_rt_addr and in_alusrc == 0), or (out_rd == in_rt_addr and in_memwrite).
- Expected external response to load_use: the hazard unit asserts flush here and freezes PC/IF-ID. No other cycle-level handshake is required.
- While stalled, the forwarding muxes keep re-evaluating against live EX/MEM and MEM/WB inputs. Op1/Op2 may therefore change during a stall, which is correct.
- Reset asserted mid-pipeline drops the in-flight instruction immediately, without waiting for a clock edge.
- No arithmetic is performed in this block; all widths pass through unchanged.

Test Plan:
- Reset: hold rst_n=0, then release → all outputs at their reset values (ALUCtrl=2, out_valid=0). Assert rst_n low mid-run → outputs clear before the next edge.
- Plain capture: in_rs_val=5, in_rt_val=7, in_alu_ctrl=ADD, alusrc=0, no forward matches → next cycle Op1=5, Op2=7, out_valid=1.
- Dual-hazard priority: registered rs_addr=8; exmem_rd=8, exmem_res=0x11; memwb_rd=8, memwb_data=0x22 (both regwrite=1) → Op1=0x11. Drop exmem_regwrite → Op1=0x22. Set rs_addr=0 with both matching 0 → Op1=registered value.
- Immediate vs store: alusrc=1, imm=0xFFFFFFFC, rt forwarded from MEM/WB as 0x99 → Op2=0xFFFFFFFC and out_store_data=0x99.
- Load-use: EX holds a lw to rd=9; ID presents rs_addr=9 → load_use=1. Assert flush at the edge → next cycle out_valid=0, out_regwrite=0, ALUCtrl=2. Repeat with rd=0 → load_use=0.
- Stall/flush interaction: stall=1 for 3 cycles → registered fields unchanged. stall=1 with flush=1 → bubble loaded. Capture with in_valid=0 and in_regwrite=1 → out_regwrite=0.
